tlb_mgr: RTL and testbench
==========================

# tlb_mgr

CP0-side TLB management unit: executes TLBP, TLBR, TLBWI and TLBWR against the 16-entry dual-search TLB. It owns the Index, Random and Wired registers and drives the TLB write port, read port and search port 1. Instruction fetch keeps search port 0. It sits between the CP0 register file and the TLB.

## Interface
- TLB_NUM, 16, number of TLB entries (power of 2)
- IDX_W, $clog2(TLB_NUM), entry index width
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- op_valid  in  1  TLB instruction request
- op_code  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
- op_ready  out  1  request accepted when op_valid&op_ready
- op_done  out  1  one-cycle completion pulse
- entryhi  in  27  {vpn2[18:0], asid[7:0]} from CP0
- entrylo0, entrylo1  in  26 each  {pfn[19:0], c[2:0], d, v, g} from CP0
- idx_we / idx_wdata  in  1 / IDX_W  MTC0 write of Index
- wired_we / wired_wdata  in  1 / IDX_W  MTC0 write of Wired
- index, random, wired  out  IDX_W each  register values
- index_p  out  1  Index.P, probe-miss flag
- rd_we  out  1  TLBR writeback strobe to CP0 EntryHi/EntryLo0/EntryLo1
- rd_entryhi / rd_entrylo0 / rd_entrylo1  out  27 / 26 / 26  TLBR results
- p_vpn2 / p_asid / p_odd_page  out  19 / 8 / 1  search port 1 key; p_odd_page tied 0
- p_found / p_index  in  1 / IDX_W  search port 1 result
- wr / w_index  out  1 / IDX_W  TLB write enable and target
- w_vpn2, w_asid, w_g, w_pfn0/1, w_c0/1, w_d0/1, w_v0/1  out  19,8,1,20,3,1,1  write data
- r_index  out  IDX_W  TLB read index
- r_vpn2, r_asid, r_g, r_pfn0/1, r_c0/1, r_d0/1, r_v0/1  in  19,8,1,20,3,1,1  read data

## Operation
- FSM states: IDLE -> EXEC -> DONE -> IDLE. op_ready=1 only in IDLE. A request in any other state is not accepted.
- On accept, latch op_code, entryhi, entrylo0 and entrylo1.
- On accept, also latch the target index: the Index value for TLBWI, the Random value for TLBWR, the Index value for TLBR.
- EXEC, TLBP: drive p_vpn2/p_asid from the latched entryhi.
  - Hit: index<=p_index, index_p<=0.
  - Miss: index_p<=1, index field unchanged.
- EXEC, TLBR: r_index=latched index. Capture r_* into the rd_* registers.
  - rd_entrylo0.g = rd_entrylo1.g = r_g.
- EXEC, TLBWI/TLBWR: wr=1 for exactly this cycle, with w_index=latched index.
  - w_g = entrylo0.g & entrylo1.g.
  - w_* take the other latched fields.
- wr, p_* and r_index values are don't-care outside EXEC. wr=0 outside EXEC.
- DONE: op_done=1. rd_we=1 only if the op is TLBR. The rd_* registers hold their values until the next TLBR.
- Random, updated every cycle:
  - wired_we: random<=TLB_NUM-1.
  - else random==wired: random<=TLB_NUM-1.
  - else random<=random-1.
  - Random keeps decrementing while an op is in flight. TLBWR uses the value sampled at accept.
- wired_we: wired<=wired_wdata. wired=TLB_NUM-1 freezes random at TLB_NUM-1.
- idx_we: index<=idx_wdata; index_p unchanged.
- idx_we in the same cycle as a TLBP hit update: the TLBP result wins.
- Reset values: state IDLE, op_ready=1, op_done=0, rd_we=0, wr=0, index=0, index_p=0, random=TLB_NUM-1, wired=0, rd_* all zero.
- Reset during EXEC: wr is gated by !reset, so no TLB write occurs, and no op_done is issued.

## Timing
- Cycle 0: accept.
- Cycle 1: EXEC. The TLB write commits at the end of cycle 1. The index/index_p update is visible in cycle 2.
- Cycle 2: DONE. op_done and rd_we are high; rd_* are valid.
- Cycle 3: op_ready=1 again. Maximum rate is one op per 3 cycles.
- Back-to-back TLBWI then TLBR to the same index returns the newly written data; the write commits before the TLBR EXEC.

## Test plan
- TLBWI: index=5, entryhi={vpn2=0x1234,asid=0x12}, lo0.g=1, lo1.g=0 -> wr pulse in cycle 1, w_index=5, w_g=0, op_done in cycle 2.
- TLBR of entry 5 after that write -> rd_we in cycle 2, rd_entryhi={0x1234,0x12}, both rd g bits=0.
- TLBP with the matching entryhi -> index=5, index_p=0. TLBP with asid=0x13 -> index_p=1, index stays 5.
- Random sequence after reset with wired=3 written:
  - random=15 after the wired_we cycle.
  - Then 14, 13 … 3, then 15 again.
  - TLBWR accepted when random=7 -> w_index=7.
- op_valid held for 3 cycles -> exactly one accept per IDLE visit.
- Simultaneous idx_we=9 and a TLBP hit at 2 -> index=2.
- Reset asserted in the EXEC cycle of a TLBWI -> wr=0, no entry change, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/tlb_mgr.sv
// CP0-side TLB manager: runs TLBP/TLBR/TLBWI/TLBWR and owns the Index, Random and Wired registers.
// Each op takes 3 cycles (accept, EXEC, DONE); op_ready is low outside IDLE, so a new op is accepted at most every 3 cycles.
module tlb_mgr #(
    parameter int TLB_NUM = 16,
    parameter int IDX_W   = $clog2(TLB_NUM)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    output logic             op_ready,
    output logic             op_done,
    input  logic [26:0]      entryhi,
    input  logic [25:0]      entrylo0,
    input  logic [25:0]      entrylo1,
    input  logic             idx_we,
    input  logic [IDX_W-1:0] idx_wdata,
    input  logic             wired_we,
    input  logic [IDX_W-1:0] wired_wdata,
    output logic [IDX_W-1:0] index,
    output logic [IDX_W-1:0] random,
    output logic [IDX_W-1:0] wired,
    output logic             index_p,
    output logic             rd_we,
    output logic [26:0]      rd_entryhi,
    output logic [25:0]      rd_entrylo0,
    output logic [25:0]      rd_entrylo1,
    output logic [18:0]      p_vpn2,
    output logic [7:0]       p_asid,
    output logic             p_odd_page,
    input  logic             p_found,
    input  logic [IDX_W-1:0] p_index,
    output logic             wr,
    output logic [IDX_W-1:0] w_index,
    output logic [18:0]      w_vpn2,
    output logic [7:0]       w_asid,
    output logic             w_g,
    output logic [19:0]      w_pfn0,
    output logic [19:0]      w_pfn1,
    output logic [2:0]       w_c0,
    output logic [2:0]       w_c1,
    output logic             w_d0,
    output logic             w_d1,
    output logic             w_v0,
    output logic             w_v1,
    output logic [IDX_W-1:0] r_index,
    input  logic [18:0]      r_vpn2,
    input  logic [7:0]       r_asid,
    input  logic             r_g,
    input  logic [19:0]      r_pfn0,
    input  logic [19:0]      r_pfn1,
    input  logic [2:0]       r_c0,
    input  logic [2:0]       r_c1,
    input  logic             r_d0,
    input  logic             r_d1,
    input  logic             r_v0,
    input  logic             r_v1
);

    localparam logic [1:0]       OP_TLBP  = 2'b00;
    localparam logic [1:0]       OP_TLBR  = 2'b01;
    localparam logic [1:0]       OP_TLBWR = 2'b11;
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(TLB_NUM - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_op;
    logic [26:0]      r_ehi;
    logic [25:0]      r_lo0;
    logic [25:0]      r_lo1;
    logic [IDX_W-1:0] r_tgt;
    logic             w_accept;
    logic             w_exec;
    logic             w_probe;

    assign w_accept = op_valid && op_ready;
    assign w_exec   = (r_state == S_EXEC);
    assign w_probe  = w_exec && (r_op == OP_TLBP);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // wr is gated by reset so a reset landing in EXEC never commits a write
    always_comb begin
        op_ready = (r_state == S_IDLE);
        op_done  = (r_state == S_DONE);
        rd_we    = (r_state == S_DONE) && (r_op == OP_TLBR);
        wr       = w_exec && r_op[1] && !reset;
    end

    // Target is snapshotted at accept; Random keeps moving during the op
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op  <= 2'b00;
            r_ehi <= '0;
            r_lo0 <= '0;
            r_lo1 <= '0;
            r_tgt <= '0;
        end else if (w_accept) begin
            r_op  <= op_code;
            r_ehi <= entryhi;
            r_lo0 <= entrylo0;
            r_lo1 <= entrylo1;
            r_tgt <= (op_code == OP_TLBWR) ? random : index;
        end
    end

    assign p_vpn2     = r_ehi[26:8];
    assign p_asid     = r_ehi[7:0];
    assign p_odd_page = 1'b0;
    assign r_index    = r_tgt;

    assign w_index = r_tgt;
    assign w_vpn2  = r_ehi[26:8];
    assign w_asid  = r_ehi[7:0];
    assign w_g     = r_lo0[0] & r_lo1[0];
    assign w_pfn0  = r_lo0[25:6];
    assign w_c0    = r_lo0[5:3];
    assign w_d0    = r_lo0[2];
    assign w_v0    = r_lo0[1];
    assign w_pfn1  = r_lo1[25:6];
    assign w_c1    = r_lo1[5:3];
    assign w_d1    = r_lo1[2];
    assign w_v1    = r_lo1[1];

    // A probe hit outranks a concurrent MTC0 Index write
    always_ff @(posedge clk) begin
        if (reset) begin
            index   <= '0;
            index_p <= 1'b0;
        end else begin
            if (w_probe && p_found) index <= p_index;
            else if (idx_we)        index <= idx_wdata;
            if (w_probe)            index_p <= ~p_found;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            random <= IDX_MAX;
            wired  <= '0;
        end else begin
            if (wired_we || (random == wired)) random <= IDX_MAX;
            else                               random <= random - 1'b1;
            if (wired_we) wired <= wired_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_entryhi  <= '0;
            rd_entrylo0 <= '0;
            rd_entrylo1 <= '0;
        end else if (w_exec && (r_op == OP_TLBR)) begin
            rd_entryhi  <= {r_vpn2, r_asid};
            rd_entrylo0 <= {r_pfn0, r_c0, r_d0, r_v0, r_g};
            rd_entrylo1 <= {r_pfn1, r_c1, r_d1, r_v1, r_g};
        end
    end

endmodule

// File: tb/tb_tlb_mgr.sv
// Bench for tlb_mgr: behavioural 16-entry TLB model plus write/completion scoreboard.
module tb_tlb_mgr;

    localparam logic [1:0] OP_P = 2'b00, OP_R = 2'b01, OP_WI = 2'b10, OP_WR = 2'b11;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, op_valid, op_ready, op_done;
    logic [1:0]  op_code;
    logic [26:0] entryhi;
    logic [25:0] entrylo0, entrylo1;
    logic        idx_we, wired_we;
    logic [3:0]  idx_wdata, wired_wdata, index, random, wired;
    logic        index_p, rd_we;
    logic [26:0] rd_entryhi;
    logic [25:0] rd_entrylo0, rd_entrylo1;
    logic [18:0] p_vpn2;
    logic [7:0]  p_asid;
    logic        p_odd_page, p_found;
    logic [3:0]  p_index;
    logic        wr;
    logic [3:0]  w_index;
    logic [18:0] w_vpn2;
    logic [7:0]  w_asid;
    logic        w_g, w_d0, w_d1, w_v0, w_v1;
    logic [19:0] w_pfn0, w_pfn1;
    logic [2:0]  w_c0, w_c1;
    logic [3:0]  r_index;
    logic [18:0] r_vpn2;
    logic [7:0]  r_asid;
    logic        r_g, r_d0, r_d1, r_v0, r_v1;
    logic [19:0] r_pfn0, r_pfn1;
    logic [2:0]  r_c0, r_c1;

    tlb_mgr #(.TLB_NUM(16)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .op_ready(op_ready), .op_done(op_done), .entryhi(entryhi),
        .entrylo0(entrylo0), .entrylo1(entrylo1), .idx_we(idx_we),
        .idx_wdata(idx_wdata), .wired_we(wired_we), .wired_wdata(wired_wdata),
        .index(index), .random(random), .wired(wired), .index_p(index_p),
        .rd_we(rd_we), .rd_entryhi(rd_entryhi), .rd_entrylo0(rd_entrylo0),
        .rd_entrylo1(rd_entrylo1), .p_vpn2(p_vpn2), .p_asid(p_asid),
        .p_odd_page(p_odd_page), .p_found(p_found), .p_index(p_index),
        .wr(wr), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_pfn1(w_pfn1), .w_c0(w_c0), .w_c1(w_c1),
        .w_d0(w_d0), .w_d1(w_d1), .w_v0(w_v0), .w_v1(w_v1), .r_index(r_index),
        .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g), .r_pfn0(r_pfn0),
        .r_pfn1(r_pfn1), .r_c0(r_c0), .r_c1(r_c1), .r_d0(r_d0), .r_d1(r_d1),
        .r_v0(r_v0), .r_v1(r_v1)
    );

    // TLB model: write at posedge, combinational read and search
    logic [18:0] m_vpn2 [16];
    logic [7:0]  m_asid [16];
    logic        m_g    [16];
    logic [24:0] m_lo0  [16];
    logic [24:0] m_lo1  [16];

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_vpn2[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0; m_lo0[i] = '0; m_lo1[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (wr) begin
            m_vpn2[w_index] <= w_vpn2;
            m_asid[w_index] <= w_asid;
            m_g[w_index]    <= w_g;
            m_lo0[w_index]  <= {w_pfn0, w_c0, w_d0, w_v0};
            m_lo1[w_index]  <= {w_pfn1, w_c1, w_d1, w_v1};
        end
    end

    assign r_vpn2 = m_vpn2[r_index];
    assign r_asid = m_asid[r_index];
    assign r_g    = m_g[r_index];
    assign {r_pfn0, r_c0, r_d0, r_v0} = m_lo0[r_index];
    assign {r_pfn1, r_c1, r_d1, r_v1} = m_lo1[r_index];

    always_comb begin
        p_found = 1'b0;
        p_index = '0;
        for (int i = 0; i < 16; i++) begin
            if (!p_found && m_vpn2[i] == p_vpn2 && (m_g[i] || m_asid[i] == p_asid)) begin
                p_found = 1'b1;
                p_index = 4'(i);
            end
        end
    end

    typedef struct { logic [3:0] idx; logic g; logic [26:0] ehi; logic [25:0] lo0; logic [25:0] lo1; } wexp_t;
    typedef struct { logic rdwe; logic chk; logic [26:0] ehi; logic [25:0] lo0; logic [25:0] lo1; } dexp_t;
    wexp_t wq[$];
    dexp_t dq[$];
    int tests = 0, fails = 0, accepts = 0;

    function automatic logic [25:0] mk_lo(input logic [19:0] pfn, input logic [2:0] c,
                                          input logic d, input logic v, input logic g);
        return {pfn, c, d, v, g};
    endfunction

    // Scoreboard: every write pulse and completion pulse must match a queued expectation
    always @(negedge clk) begin
        wexp_t we;
        dexp_t de;
        if (op_valid && op_ready) accepts++;
        if (wr) begin
            tests++;
            if (wq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write got w_index=%0d, required no write", w_index);
            end else begin
                we = wq.pop_front();
                if (w_index !== we.idx || w_g !== we.g || {w_vpn2, w_asid} !== we.ehi ||
                    {w_pfn0, w_c0, w_d0, w_v0} !== we.lo0[25:1] || {w_pfn1, w_c1, w_d1, w_v1} !== we.lo1[25:1]) begin
                    fails++;
                    $display("FAIL write_data got idx=%0d g=%0b hi=%h lo0=%h lo1=%h, required idx=%0d g=%0b hi=%h lo0=%h lo1=%h",
                             w_index, w_g, {w_vpn2, w_asid}, {w_pfn0, w_c0, w_d0, w_v0}, {w_pfn1, w_c1, w_d1, w_v1},
                             we.idx, we.g, we.ehi, we.lo0[25:1], we.lo1[25:1]);
                end
            end
        end
        if (op_done) begin
            tests++;
            if (dq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done got op_done=1, required no completion");
            end else begin
                de = dq.pop_front();
                if (rd_we !== de.rdwe || (de.chk && (rd_entryhi !== de.ehi || rd_entrylo0 !== de.lo0 || rd_entrylo1 !== de.lo1))) begin
                    fails++;
                    $display("FAIL done_data got rd_we=%0b hi=%h lo0=%h lo1=%h, required rd_we=%0b hi=%h lo0=%h lo1=%h",
                             rd_we, rd_entryhi, rd_entrylo0, rd_entrylo1, de.rdwe, de.ehi, de.lo0, de.lo1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_index(input logic [3:0] v);
        idx_we = 1'b1; idx_wdata = v;
        tick();
        idx_we = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [26:0] hi, input logic [25:0] lo0, input logic [25:0] lo1);
        op_code = op; entryhi = hi; entrylo0 = lo0; entrylo1 = lo1;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; op_valid = 1'b0; op_code = 2'b00; entryhi = '0; entrylo0 = '0; entrylo1 = '0;
        idx_we = 1'b0; idx_wdata = '0; wired_we = 1'b0; wired_wdata = '0;
        tick(); tick();
        tests++;
        if ({op_ready, op_done, rd_we, wr, index_p} !== 5'b10000) begin
            fails++; $display("FAIL reset_flags got %b, required 10000", {op_ready, op_done, rd_we, wr, index_p});
        end
        tests++;
        if (index !== 4'd0 || random !== 4'd15 || wired !== 4'd0) begin
            fails++; $display("FAIL reset_regs got index=%0d random=%0d wired=%0d, required 0/15/0", index, random, wired);
        end
        tests++;
        if (rd_entryhi !== '0 || rd_entrylo0 !== '0 || rd_entrylo1 !== '0) begin
            fails++; $display("FAIL reset_rd got %h %h %h, required zeros", rd_entryhi, rd_entrylo0, rd_entrylo1);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_tlbwi();
        logic [25:0] lo0 = mk_lo(20'hABCDE, 3'd3, 1'b1, 1'b1, 1'b1);
        logic [25:0] lo1 = mk_lo(20'h13579, 3'd2, 1'b0, 1'b1, 1'b0);
        set_index(4'd5);
        tests++;
        if (index !== 4'd5) begin fails++; $display("FAIL idx_write got %0d, required 5", index); end
        wq.push_back('{4'd5, 1'b0, {19'h1234, 8'h12}, lo0, lo1});
        dq.push_back('{1'b0, 1'b0, 27'd0, 26'd0, 26'd0});
        tests++;
        if (op_ready !== 1'b1) begin fails++; $display("FAIL wi_ready got %0b, required 1", op_ready); end
        issue(OP_WI, {19'h1234, 8'h12}, lo0, lo1);
        tests++;
        if ({wr, op_ready, op_done} !== 3'b100) begin
            fails++; $display("FAIL wi_cycle1 got wr/ready/done=%b, required 100", {wr, op_ready, op_done});
        end
        tick();
        tests++;
        if ({wr, op_done, rd_we} !== 3'b010) begin
            fails++; $display("FAIL wi_cycle2 got wr/done/rd_we=%b, required 010", {wr, op_done, rd_we});
        end
        tick();
        tests++;
        if ({op_ready, op_done} !== 2'b10) begin
            fails++; $display("FAIL wi_cycle3 got ready/done=%b, required 10", {op_ready, op_done});
        end
    endtask

    task automatic test_back_to_back();
        logic [25:0] lo0 = mk_lo(20'hABCDE, 3'd3, 1'b1, 1'b1, 1'b0);
        logic [25:0] lo1 = mk_lo(20'h13579, 3'd2, 1'b0, 1'b1, 1'b0);
        dq.push_back('{1'b1, 1'b1, {19'h1234, 8'h12}, lo0, lo1});
        issue(OP_R, '0, '0, '0);
        tick();
        tests++;
        if (rd_we !== 1'b1 || rd_entryhi !== {19'h1234, 8'h12} || rd_entrylo0[0] !== 1'b0 || rd_entrylo1[0] !== 1'b0) begin
            fails++; $display("FAIL tlbr_cycle2 got rd_we=%0b hi=%h g0=%0b g1=%0b, required 1 %h 0 0",
                              rd_we, rd_entryhi, rd_entrylo0[0], rd_entrylo1[0], {19'h1234, 8'h12});
        end
        tick();
    endtask

    task automatic test_tlbp();
        set_index(4'd0);
        dq.push_back('{1'b0, 1'b0, 27'd0, 26'd0, 26'd0});
        issue(OP_P, {19'h1234, 8'h12}, '0, '0);
        tick();
        tests++;
        if (index !== 4'd5 || index_p !== 1'b0) begin
            fails++; $display("FAIL tlbp_hit got index=%0d p=%0b, required 5 0", index, index_p);
        end
        tick();
        dq.push_back('{1'b0, 1'b0, 27'd0, 26'd0, 26'd0});
        issue(OP_P, {19'h1234, 8'h13}, '0, '0);
        tick();
        tests++;
        if (index !== 4'd5 || index_p !== 1'b1) begin
            fails++; $display("FAIL tlbp_miss got index=%0d p=%0b, required 5 1", index, index_p);
        end
        tick();
        tests++;
        if (rd_entryhi !== {19'h1234, 8'h12} || rd_entrylo1 !== mk_lo(20'h13579, 3'd2, 1'b0, 1'b1, 1'b0)) begin
            fails++; $display("FAIL rd_hold got hi=%h lo1=%h, required held TLBR data", rd_entryhi, rd_entrylo1);
        end
    endtask

    task automatic test_idx_conflict();
        logic [25:0] lo0 = mk_lo(20'h00042, 3'd0, 1'b0, 1'b1, 1'b0);
        logic [25:0] lo1 = mk_lo(20'h00043, 3'd0, 1'b0, 1'b1, 1'b0);
        set_index(4'd2);
        tests++;
        if (index !== 4'd2 || index_p !== 1'b1) begin
            fails++; $display("FAIL idx_keeps_p got index=%0d p=%0b, required 2 1", index, index_p);
        end
        wq.push_back('{4'd2, 1'b0, {19'h0777, 8'h05}, lo0, lo1});
        dq.push_back('{1'b0, 1'b0, 27'd0, 26'd0, 26'd0});
        issue(OP_WI, {19'h0777, 8'h05}, lo0, lo1);
        tick(); tick();
        dq.push_back('{1'b0, 1'b0, 27'd0, 26'd0, 26'd0});
        issue(OP_P, {19'h0777, 8'h05}, '0, '0);
        idx_we = 1'b1; idx_wdata = 4'd9;
        tick();
        idx_we = 1'b0;
        tests++;
        if (index !== 4'd2 || index_p !== 1'b0) begin
            fails++; $display("FAIL probe_vs_mtc0 got index=%0d p=%0b, required 2 0", index, index_p);
        end
        tick();
    endtask

    task automatic test_random();
        logic [25:0] lo = mk_lo(20'h0BEEF, 3'd1, 1'b1, 1'b1, 1'b1);
        wired_we = 1'b1; wired_wdata = 4'd3;
        tick();
        wired_we = 1'b0;
        tests++;
        if (random !== 4'd15 || wired !== 4'd3) begin
            fails++; $display("FAIL wired_set got random=%0d wired=%0d, required 15 3", random, wired);
        end
        for (int k = 0; k < 21; k++) begin
            tick();
            tests++;
            if (random !== 4'(15 - ((k + 1) % 13))) begin
                fails++; $display("FAIL random_seq step %0d got %0d, required %0d", k, random, 15 - ((k + 1) % 13));
            end
        end
        wq.push_back('{4'd7, 1'b1, {19'h2222, 8'h33}, lo, lo});
        dq.push_back('{1'b0, 1'b0, 27'd0, 26'd0, 26'd0});
        issue(OP_WR, {19'h2222, 8'h33}, lo, lo);
        tests++;
        if (random !== 4'd6) begin fails++; $display("FAIL random_in_exec got %0d, required 6", random); end
        tick(); tick();
        wired_we = 1'b1; wired_wdata = 4'd15;
        tick();
        wired_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (random !== 4'd15) begin fails++; $display("FAIL random_frozen step %0d got %0d, required 15", k, random); end
        end
        wired_we = 1'b1; wired_wdata = 4'd0;
        tick();
        wired_we = 1'b0;
    endtask

    task automatic test_hold_valid();
        int a0 = accepts;
        dq.push_back('{1'b0, 1'b0, 27'd0, 26'd0, 26'd0});
        op_code = OP_P; entryhi = {19'h1234, 8'h12};
        op_valid = 1'b1;
        tick(); tick(); tick();
        op_valid = 1'b0;
        tick(); tick(); tick(); tick();
        tests++;
        if (accepts - a0 !== 1) begin fails++; $display("FAIL hold_valid accepts got %0d, required 1", accepts - a0); end
    endtask

    task automatic test_reset_exec();
        set_index(4'd5);
        issue(OP_WI, {19'h5555, 8'h01}, mk_lo(20'h1, 3'd0, 1'b0, 1'b1, 1'b0), mk_lo(20'h2, 3'd0, 1'b0, 1'b1, 1'b0));
        reset = 1'b1;
        #1;
        tests++;
        if (wr !== 1'b0) begin fails++; $display("FAIL reset_exec_wr got %0b, required 0", wr); end
        tick();
        tests++;
        if ({op_ready, op_done, rd_we, wr, index_p} !== 5'b10000 || index !== 4'd0 || random !== 4'd15 ||
            wired !== 4'd0 || rd_entryhi !== '0 || rd_entrylo0 !== '0) begin
            fails++; $display("FAIL reset_exec_state got flags=%b index=%0d random=%0d wired=%0d hi=%h, required 10000 0 15 0 0",
                              {op_ready, op_done, rd_we, wr, index_p}, index, random, wired, rd_entryhi);
        end
        reset = 1'b0;
        tests++;
        if (m_vpn2[5] !== 19'h1234) begin fails++; $display("FAIL reset_exec_entry got vpn2=%h, required 1234", m_vpn2[5]); end
        tick(); tick(); tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tlbwi();
        test_back_to_back();
        test_tlbp();
        test_idx_conflict();
        test_random();
        test_hold_valid();
        test_reset_exec();
        tests++;
        if (wq.size() != 0 || dq.size() != 0) begin
            fails++; $display("FAIL scoreboard_drain got %0d writes %0d dones pending, required 0 0", wq.size(), dq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
